// File: rtl/prog_delay_line_if.sv
// Bus bundle for prog_delay_line: sample stream in, delayed stream out,
// plus the runtime delay programming and clear controls.
// The master drives samples and control; the slave is the delay line itself.
interface prog_delay_line_if #(
  parameter int SIG_WIDTH = 16,
  parameter int DW        = 11,
  parameter int CW        = 1
);
  logic                 clr;
  logic                 in_valid;
  logic [SIG_WIDTH-1:0] in_data;
  logic                 dly_load;
  logic [DW-1:0]        dly_in;
  logic [DW-1:0]        dly_cur;
  logic                 out_valid;
  logic [SIG_WIDTH-1:0] out_data;
  logic [CW-1:0]        out_chan;

  modport master (
    output clr, in_valid, in_data, dly_load, dly_in,
    input  dly_cur, out_valid, out_data, out_chan
  );

  modport slave (
    input  clr, in_valid, in_data, dly_load, dly_in,
    output dly_cur, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/prog_delay_line.sv
// Runtime-programmable, multi-channel TDM sample delay line.
// Samples live in a circular RAM of (MAX_DEPTH+1)*CHANNELS entries; each output
// is the same-channel input from dly_cur samples earlier, one cycle after accept.
// Unwritten history reads as zero, and a delay of 0 bypasses the RAM entirely.
// Optional build macro DLY_CLR_ON_LOAD_EN: a delay load also restarts the fill
// count, so outputs stay zero until the new delay's worth of samples is stored.
module prog_delay_line #(
  parameter int SIG_WIDTH = 16,
  parameter int MAX_DEPTH = 1024,
  parameter int CHANNELS  = 1,
  parameter int DLY_INIT  = 515
) (
  input  logic               clk,
  input  logic               rst,
  prog_delay_line_if.slave   bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int N  = (MAX_DEPTH + 1) * CHANNELS;
  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;

  logic [SIG_WIDTH-1:0] mem [N];
  logic [SIG_WIDTH-1:0] ram_q;
  logic [SIG_WIDTH-1:0] byp_q;
  logic                 use_zero;
  logic                 use_byp;

  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        chan_cnt;
  logic [PW-1:0]        fill_cnt;
  logic [DW-1:0]        dly_cur;
  logic                 out_valid;
  logic [CW-1:0]        out_chan;

  logic                 accept;
  logic [PW-1:0]        off_w;
  logic [PW-1:0]        wr_ext;
  logic [PW-1:0]        rd_full;
  logic [AW-1:0]        rd_addr;
  logic [DW-1:0]        dly_clamped;

  // clr wins over a sample, so a cleared cycle never touches RAM or counters
  assign accept = bus.in_valid && !bus.clr;

  // Distance back into the interleaved buffer, and the wrapped read address
  always_comb begin
    off_w   = PW'(dly_cur) * PW'(CHANNELS);
    wr_ext  = PW'(wr_ptr);
    rd_full = (wr_ext >= off_w) ? (wr_ext - off_w) : (wr_ext + PW'(N) - off_w);
    rd_addr = rd_full[AW-1:0];
    dly_clamped = (bus.dly_in > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : bus.dly_in;
  end

  // RAM port: the registered read sees the old contents before this cycle's write
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.in_data;
      ram_q       <= mem[rd_addr];
    end
  end

  // Pointers, fill tracking, programmed delay and output qualifiers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      chan_cnt  <= '0;
      fill_cnt  <= '0;
      dly_cur   <= DW'(DLY_INIT);
      out_valid <= 1'b0;
      out_chan  <= '0;
      use_zero  <= 1'b1;
      use_byp   <= 1'b0;
      byp_q     <= '0;
    end else begin
      out_valid <= accept;
      if (bus.clr) begin
        wr_ptr   <= '0;
        chan_cnt <= '0;
        fill_cnt <= '0;
      end else if (accept) begin
        wr_ptr   <= (wr_ptr == AW'(N - 1)) ? '0 : wr_ptr + AW'(1);
        chan_cnt <= (chan_cnt == CW'(CHANNELS - 1)) ? '0 : chan_cnt + CW'(1);
        if (fill_cnt != PW'(N))
          fill_cnt <= fill_cnt + PW'(1);
        out_chan <= chan_cnt;
        use_byp  <= (dly_cur == '0);
        use_zero <= (dly_cur != '0) && (fill_cnt < off_w);
        byp_q    <= bus.in_data;
      end
      if (bus.dly_load) begin
        dly_cur <= dly_clamped;
`ifdef DLY_CLR_ON_LOAD_EN
        fill_cnt <= '0;
`endif
      end
    end
  end

  assign bus.out_data  = use_zero ? '0 : (use_byp ? byp_q : ram_q);
  assign bus.out_valid = out_valid;
  assign bus.out_chan  = out_chan;
  assign bus.dly_cur   = dly_cur;

endmodule

// File: tb/tb_prog_delay_line.sv
// Testbench for prog_delay_line: two instances (1 channel / depth 1024, and
// 2 channels / depth 4) driven by directed scenarios and random traffic,
// checked against a queue-based history model of the delay line.
module tb_prog_delay_line;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  prog_delay_line_if #(.SIG_WIDTH(16), .DW(11), .CW(1)) bus_a ();
  prog_delay_line_if #(.SIG_WIDTH(16), .DW(3),  .CW(1)) bus_b ();

  prog_delay_line #(.SIG_WIDTH(16), .MAX_DEPTH(1024), .CHANNELS(1), .DLY_INIT(515))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  prog_delay_line #(.SIG_WIDTH(16), .MAX_DEPTH(4), .CHANNELS(2), .DLY_INIT(3))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int          m_dly[2];
  int          m_fresh[2];
  int          m_cnt[2];
  int          m_chan[2];
  logic [15:0] m_out[2];
  bit          m_val[2];
  logic [15:0] hist0[$];
  logic [15:0] hist1[$];

  function automatic int chans(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int max_d(input int i);
    return (i == 0) ? 1024 : 4;
  endfunction

  function automatic logic [15:0] hist_at(input int i, input int k);
    return (i == 0) ? hist0[k] : hist1[k];
  endfunction

  task automatic hist_push(input int i, input logic [15:0] d);
    int depth;
    depth = (max_d(i) + 1) * chans(i);
    if (i == 0) begin
      hist0.push_front(d);
      if (hist0.size() > depth) void'(hist0.pop_back());
    end else begin
      hist1.push_front(d);
      if (hist1.size() > depth) void'(hist1.pop_back());
    end
  endtask

  task automatic model_reset();
    m_dly[0] = 515;
    m_dly[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_fresh[i] = 0;
      m_cnt[i]   = 0;
      m_chan[i]  = 0;
      m_out[i]   = '0;
      m_val[i]   = 1'b0;
    end
    hist0.delete();
    hist1.delete();
  endtask

  // One clock edge of the model: output is the sample dly*CHANNELS accepts back
  task automatic model_edge(input int i, input bit v, input logic [15:0] d,
                            input bit ld, input int din, input bit c);
    int off;
    if (v && !c) begin
      off = m_dly[i] * chans(i);
      if (m_dly[i] == 0)          m_out[i] = d;
      else if (m_fresh[i] >= off) m_out[i] = hist_at(i, off - 1);
      else                        m_out[i] = '0;
      m_val[i]  = 1'b1;
      m_chan[i] = m_cnt[i] % chans(i);
      hist_push(i, d);
      m_cnt[i]++;
      m_fresh[i]++;
    end else begin
      m_val[i] = 1'b0;
    end
    if (c) begin
      if (i == 0) hist0.delete(); else hist1.delete();
      m_cnt[i]   = 0;
      m_fresh[i] = 0;
    end
    if (ld) begin
      m_dly[i] = (din > max_d(i)) ? max_d(i) : din;
`ifdef DLY_CLR_ON_LOAD_EN
      m_fresh[i] = 0;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input int i);
    if (i == 0) begin
      chk("a_valid", 32'(bus_a.out_valid), 32'(m_val[0]));
      chk("a_data",  32'(bus_a.out_data),  32'(m_out[0]));
      chk("a_chan",  32'(bus_a.out_chan),  32'(m_chan[0]));
      chk("a_dly",   32'(bus_a.dly_cur),   32'(m_dly[0]));
    end else begin
      chk("b_valid", 32'(bus_b.out_valid), 32'(m_val[1]));
      chk("b_data",  32'(bus_b.out_data),  32'(m_out[1]));
      chk("b_chan",  32'(bus_b.out_chan),  32'(m_chan[1]));
      chk("b_dly",   32'(bus_b.dly_cur),   32'(m_dly[1]));
    end
  endtask

  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.dly_load = 1'b0;
    bus_a.dly_in = '0;     bus_a.clr = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.dly_load = 1'b0;
    bus_b.dly_in = '0;     bus_b.clr = 1'b0;
  endtask

  // Drive one cycle on instance i (the other idles), then check both against the model
  task automatic apply_stimulus(input int i, input bit v, input logic [15:0] d,
                                input bit ld, input int din, input bit c);
    int din_eff;
    @(negedge clk);
    idle_inputs();
    if (i == 0) begin
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.dly_load = ld;
      bus_a.dly_in = din[10:0]; bus_a.clr = c;
      din_eff = din & 2047;
    end else begin
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.dly_load = ld;
      bus_b.dly_in = din[2:0]; bus_b.clr = c;
      din_eff = din & 7;
    end
    @(posedge clk);
    model_edge(i, v, d, ld, din_eff, c);
    model_edge(1 - i, 1'b0, '0, 1'b0, 0, 1'b0);
    #1;
    check_output(0);
    check_output(1);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_output(0);
    check_output(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          exp_t1[6];
    logic [15:0] d;
    logic [15:0] t3_in[5];
    logic [15:0] t3_out[5];
    int          t3_chan[5];
    int          i;

    exp_t1 = '{0, 0, 0, 1, 2, 3};
    t3_in   = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002};
    t3_out  = '{16'h0000, 16'h0000, 16'hA000, 16'hB000, 16'hA001};
    t3_chan = '{0, 1, 0, 1, 0};

    idle_inputs();
    $display("[TB] reset");
    do_reset();

    $display("[TB] T1 delay 3, single channel");
    apply_stimulus(0, 1'b0, '0, 1'b1, 3, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(0, 1'b1, 16'(k), 1'b0, 0, 1'b0);
      chk("t1_data", 32'(bus_a.out_data), 32'(exp_t1[k-1]));
    end

    $display("[TB] T2 bypass and clamp");
    apply_stimulus(0, 1'b0, '0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d = 16'($urandom);
      apply_stimulus(0, 1'b1, d, 1'b0, 0, 1'b0);
      chk("t2_bypass", 32'(bus_a.out_data), 32'(d));
    end
    apply_stimulus(0, 1'b0, '0, 1'b1, 2000, 1'b0);
    chk("t2_clamp", 32'(bus_a.dly_cur), 32'd1024);

    $display("[TB] T3 two channels, delay 1");
    apply_stimulus(1, 1'b0, '0, 1'b1, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, 1'b1, t3_in[k], 1'b0, 0, 1'b0);
      chk("t3_data", 32'(bus_b.out_data), 32'(t3_out[k]));
      chk("t3_chan", 32'(bus_b.out_chan), 32'(t3_chan[k]));
    end

    $display("[TB] T4 wrap at max depth with gaps");
    apply_stimulus(1, 1'b0, '0, 1'b1, 4, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0) apply_stimulus(1, 1'b0, '0, 1'b0, 0, 1'b0);
      apply_stimulus(1, 1'b1, 16'($urandom), 1'b0, 0, 1'b0);
    end

    $display("[TB] T5 delay change mid-stream");
    apply_stimulus(0, 1'b0, '0, 1'b1, 3, 1'b1);
    for (int k = 0; k < 10; k++) apply_stimulus(0, 1'b1, 16'(16'h100 + k), 1'b0, 0, 1'b0);
    apply_stimulus(0, 1'b0, '0, 1'b1, 1, 1'b0);
    for (int k = 10; k < 16; k++) apply_stimulus(0, 1'b1, 16'(16'h100 + k), 1'b0, 0, 1'b0);

    $display("[TB] T6 clear and async reset");
    apply_stimulus(0, 1'b1, 16'h7777, 1'b0, 0, 1'b1);
    chk("t6_clr_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t6_clr_dly", 32'(bus_a.dly_cur), 32'd1);
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1'b1, 16'(16'h200 + k), 1'b0, 0, 1'b0);
    apply_stimulus(1, 1'b1, 16'h5A5A, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_data", 32'(bus_a.out_data), 32'd0);
    chk("t6_rst_valid", 32'(bus_b.out_valid), 32'd0);
    check_output(0);
    check_output(1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      i = int'($urandom_range(0, 1));
      apply_stimulus(i,
                     ($urandom_range(0, 3) != 0),
                     16'($urandom),
                     ($urandom_range(0, 15) == 0),
                     (i == 0) ? (($urandom_range(0, 9) == 0) ? 2000 : int'($urandom_range(0, 6)))
                              : int'($urandom_range(0, 7)),
                     ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
